// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    SETTLE,
    RELEASE_PIX,
    RUN
  } state_t;

  // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-high reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: non-blocking assignments make both stages sample together, so the chain stays two flops deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Sequences staggered pixel/draw resets from the PLL lock flag, with
// glitch-filtered lock-loss detection and a saturating loss counter.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4096,
  parameter int STAGGER_CYCLES = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOSS_FILTER    = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_count,
  output logic             rst_pix,
  output logic             rst_draw,
  output logic             ready,
  output logic [CNT_W-1:0] lock_lost_count
);

  localparam int CNT_MAX = (SETTLE_CYCLES > STAGGER_CYCLES)
                         ? ((SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES)
                         : ((STAGGER_CYCLES > HOLD_CYCLES) ? STAGGER_CYCLES : HOLD_CYCLES);
  localparam int CW = cnt_width(CNT_MAX);
  localparam int LW = cnt_width(LOSS_FILTER);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST    = LW'(LOSS_FILTER - 1);

  logic          lk;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [LW-1:0] lf, lf_nx;
  logic          loss;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lf_nx    = '0;
    loss     = 1'b0;
    case (state)
      RESET_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        cnt_nx = '0;
        if (lk) state_nx = SETTLE;
      end
      SETTLE: begin
        // A dropout here is not a loss event: lock was never declared.
        if (!lk) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = RELEASE_PIX;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RELEASE_PIX, RUN: begin
        if (!lk) begin
          if (lf == LOSS_LAST) loss = 1'b1;
          else                 lf_nx = lf + LW'(1);
        end
        if (loss) begin
          state_nx = RESET_HOLD;
          cnt_nx   = '0;
        end else if (state == RELEASE_PIX) begin
          if (cnt == STAGGER_LAST) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = RESET_HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the state and can never glitch low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RESET_HOLD;
      cnt             <= '0;
      lf              <= '0;
      rst_pix         <= 1'b1;
      rst_draw        <= 1'b1;
      ready           <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lf       <= lf_nx;
      rst_pix  <= !(state_nx inside {RELEASE_PIX, RUN});
      rst_draw <= (state_nx != RUN);
      ready    <= (state_nx == RUN);
      if (clear_count)
        lock_lost_count <= '0;
      else if (loss && !(&lock_lost_count))
        lock_lost_count <= lock_lost_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output words are queued with
// the clock edge they belong to and compared when that edge is reached.
module tb_pll_reset_seq;
  import pll_reset_pkg::*;

  localparam int SETTLE  = 64;
  localparam int STAGGER = 8;
  localparam int HOLD    = 16;
  localparam int LOSS    = 4;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_locked = 1'b0;
  logic             clear_count = 1'b0;
  logic             rst_pix, rst_draw, ready;
  logic [CNT_W-1:0] lock_lost_count;

  pll_reset_seq #(
    .SETTLE_CYCLES  (SETTLE),
    .STAGGER_CYCLES (STAGGER),
    .HOLD_CYCLES    (HOLD),
    .LOSS_FILTER    (LOSS),
    .CNT_W          (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .clear_count     (clear_count),
    .rst_pix         (rst_pix),
    .rst_draw        (rst_draw),
    .ready           (ready),
    .lock_lost_count (lock_lost_count)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Expected word layout: {rst_pix, rst_draw, ready, lock_lost_count[1:0]}
  typedef struct {
    string      name;
    int         at;
    logic [4:0] v;
  } exp_t;
  exp_t sb[$];

  task automatic expect_at(input string name, input int at, input logic [4:0] v);
    exp_t e;
    e.name = name;
    e.at   = at;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic next_exp(output exp_t e);
    e = sb.pop_front();
    while (cyc < e.at) @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pix_low(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rst_pix === 1'b0) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Lock stable from t0: hold, settle, staggered release.
  task automatic test_reset();
    int r, f;
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    pll_locked = 1'b1;
    tick(2);
    rst = 1'b0;
    r = cyc;
    expect_at("reset_state", r, 5'b11000);
    expect_at("hold_last", r + HOLD, 5'b11000);
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
    wait_pix_low(200, f);
    vectors++;
    if (f < 0 || (f - r) < HOLD + 1 + SETTLE || (f - r) > HOLD + 3 + SETTLE + 1) begin
      miscompares++;
      $display("FAIL pix_release_time: observed %0d clocks, required %0d..%0d", f - r,
               HOLD + 1 + SETTLE, HOLD + 4 + SETTLE);
    end
    if (f >= 0) begin
      expect_at("pix_only", f, 5'b01000);
      expect_at("draw_stagger_last", f + STAGGER - 1, 5'b01000);
      expect_at("draw_release", f + STAGGER, 5'b00100);
    end
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
  endtask

  // Low pulse of LOSS-1 clocks in RUN must be ignored.
  task automatic test_glitch();
    int m;
    exp_t e;
    m = cyc;
    pll_locked = 1'b0;
    expect_at("glitch_mid", m + 4, 5'b00100);
    expect_at("glitch_after", m + 8, 5'b00100);
    tick(LOSS - 1);
    pll_locked = 1'b1;
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
  endtask

  // 10-clock loss: trip on 4th synced low sample, then full re-sequence.
  task automatic test_real_loss();
    int m;
    exp_t e;
    m = cyc;
    pll_locked = 1'b0;
    expect_at("loss_pre_trip", m + 5, 5'b00100);
    expect_at("loss_trip", m + 6, 5'b11001);
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
    tick(4);
    pll_locked = 1'b1;
    expect_at("reseq_settle_last", m + 86, 5'b11001);
    expect_at("reseq_pix", m + 87, 5'b01001);
    expect_at("reseq_stagger_last", m + 94, 5'b01001);
    expect_at("reseq_run", m + 95, 5'b00101);
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
  endtask

  // Async rst in RELEASE_PIX takes effect before the next edge.
  task automatic test_async_reset();
    int m, f;
    exp_t e;
    m = cyc;
    pll_locked = 1'b0;
    expect_at("loss2_trip", m + 6, 5'b11010);
    tick(6);
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
    pll_locked = 1'b1;
    wait_pix_low(300, f);
    vectors++;
    if (f < 0) begin
      miscompares++;
      $display("FAIL reach_release_pix: rst_pix still %b after 300 clocks, required 0", rst_pix);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    expect_at("async_outputs", cyc, 5'b11000);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b, required %b", e.name,
               {rst_pix, rst_draw, ready, lock_lost_count}, e.v);
    end
    vectors++;
    if (dut.state !== RESET_HOLD) begin
      miscompares++;
      $display("FAIL async_state: observed %0d, required %0d", dut.state, RESET_HOLD);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-clock dropout during SETTLE restarts it from the final rise.
  task automatic test_bounce();
    int a;
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(HOLD + 4);
    pll_locked = 1'b1;
    tick(30);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    a = cyc;
    expect_at("bounce_no_early_release", a + 36, 5'b11000);
    expect_at("bounce_settle_last", a + 66, 5'b11000);
    expect_at("bounce_pix", a + 67, 5'b01000);
    expect_at("bounce_run", a + 67 + STAGGER, 5'b00100);
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
  endtask

  // Five losses saturate a 2-bit count; clear beats a coincident 6th loss.
  task automatic test_saturation();
    int m;
    bit ok;
    exp_t e;
    logic [1:0] c;
    for (int k = 0; k < 5; k++) begin
      m = cyc;
      c = (k >= 2) ? 2'd3 : 2'(k + 1);
      pll_locked = 1'b0;
      expect_at($sformatf("sat_loss%0d", k + 1), m + 6, {3'b110, c});
      tick(6);
      while (sb.size() > 0) begin
        next_exp(e);
        vectors++;
        if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
          miscompares++;
          $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                   {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
        end
      end
      pll_locked = 1'b1;
      wait_ready(300, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL sat_rerun%0d: ready %b after 300 clocks, required 1", k + 1, ready);
      end
    end
    m = cyc;
    pll_locked = 1'b0;
    expect_at("clear_beats_loss", m + 6, 5'b11000);
    tick(5);
    clear_count = 1'b1;
    tick(1);
    clear_count = 1'b0;
    while (sb.size() > 0) begin
      next_exp(e);
      vectors++;
      if (cyc != e.at || {rst_pix, rst_draw, ready, lock_lost_count} !== e.v) begin
        miscompares++;
        $display("FAIL %s: cycle %0d observed %b, required %b at cycle %0d", e.name, cyc,
                 {rst_pix, rst_draw, ready, lock_lost_count}, e.v, e.at);
      end
    end
    pll_locked = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_real_loss();
    test_async_reset();
    test_bounce();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
